// File: rtl/modexp_pkg.sv
// Shared constants for the modular-exponentiation datapath, its controller and the bench.
// The controller state encoding lives here so both sides agree on it.
package modexp_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_EXP_WIDTH = 16;

  typedef enum logic [2:0] {
    WAITING    = 3'd0,
    INITIALIZE = 3'd1,
    MULTIPLY   = 3'd2,
    MODULO     = 3'd3,
    DONE       = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/modexp_if.sv
// Upstream operand-set handshake: valid/ready, a transfer happens on a clock edge
// where in_valid && in_ready; the source holds its payload stable until then.
interface modexp_if
  import modexp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_base;
  logic [EXP_WIDTH-1:0] in_exponent;
  logic [WIDTH-1:0]     in_modulus;

  modport master (
    output in_valid, in_base, in_exponent, in_modulus,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_base, in_exponent, in_modulus,
    output in_ready
  );

endinterface

// File: rtl/modexp_operand_buffer.sv
// One-entry operand buffer: accepts a set when empty, releases it when the
// datapath consumes it on initialize.
module modexp_operand_buffer
  import modexp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  modexp_if.slave              up,
  input  logic                 consume,
  output logic                 buf_full,
  output logic [WIDTH-1:0]     buf_base,
  output logic [EXP_WIDTH-1:0] buf_exponent,
  output logic [WIDTH-1:0]     buf_modulus
);

  assign up.in_ready = !buf_full;

  // Accept and consume are mutually exclusive: accept needs an empty buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full     <= 1'b0;
      buf_base     <= '0;
      buf_exponent <= '0;
      buf_modulus  <= '0;
    end else if (up.in_valid && !buf_full) begin
      buf_full     <= 1'b1;
      buf_base     <= up.in_base;
      buf_exponent <= up.in_exponent;
      buf_modulus  <= up.in_modulus;
    end else if (consume) begin
      buf_full <= 1'b0;
    end
  end

endmodule

// File: rtl/modexp_datapath.sv
// Square-free modexp datapath: repeated acc*base / mod steps driven by the
// external controller's strobes, result registered on done.
module modexp_datapath
  import modexp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  modexp_if.slave          up,
  output logic             input_data_ready,
  input  logic             initialize,
  input  logic             en_multiply,
  input  logic             en_modulo,
  input  logic             done,
  output logic             is_multiplication_done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             error
);

  logic                 buf_full;
  logic [WIDTH-1:0]     buf_base;
  logic [EXP_WIDTH-1:0] buf_exponent;
  logic [WIDTH-1:0]     buf_modulus;

  logic                 job_active;
  logic [EXP_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     base_r;
  logic [WIDTH-1:0]     mod_r;
  logic [2*WIDTH-1:0]   prod;

  logic [2*WIDTH-1:0]   acc_ext;
  logic [2*WIDTH-1:0]   base_ext;
  logic [2*WIDTH-1:0]   mod_ext;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH-1:0]     prod_red;
  logic [WIDTH-1:0]     base_red;

  modexp_operand_buffer #(
    .WIDTH     (WIDTH),
    .EXP_WIDTH (EXP_WIDTH)
  ) u_buf (
    .clk          (clk),
    .reset        (reset),
    .up           (up),
    .consume      (initialize && buf_full),
    .buf_full     (buf_full),
    .buf_base     (buf_base),
    .buf_exponent (buf_exponent),
    .buf_modulus  (buf_modulus)
  );

  assign input_data_ready       = buf_full;
  assign is_multiplication_done = (cnt == '0);

  // Operands widened so the product keeps all 2*WIDTH bits.
  assign acc_ext   = {{WIDTH{1'b0}}, acc};
  assign base_ext  = {{WIDTH{1'b0}}, base_r};
  assign mod_ext   = {{WIDTH{1'b0}}, mod_r};
  assign prod_next = acc_ext * base_ext;

  // Reduction by a zero modulus is defined as zero rather than left undefined.
  assign prod_red = (mod_r == '0) ? '0 : WIDTH'(prod % mod_ext);
  assign base_red = (buf_modulus == '0) ? '0 : buf_base % buf_modulus;

  always_ff @(posedge clk) begin
    if (reset) begin
      job_active   <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      prod         <= '0;
      base_r       <= '0;
      mod_r        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (initialize) begin
        if (buf_full) begin
          mod_r      <= buf_modulus;
          base_r     <= base_red;
          cnt        <= buf_exponent;
          acc        <= (buf_modulus <= WIDTH'(1)) ? '0 : WIDTH'(1);
          job_active <= 1'b1;
        end else begin
          job_active <= 1'b0;
          cnt        <= '0;
        end
      end else if (en_modulo) begin
        acc <= prod_red;
      end else if (en_multiply) begin
        if (cnt != '0) begin
          prod <= prod_next;
          cnt  <= cnt - EXP_WIDTH'(1);
        end
      end else if (done && job_active) begin
        result       <= acc;
        error        <= (mod_r == '0);
        result_valid <= 1'b1;
        job_active   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modexp_datapath.sv
// Bench for modexp_datapath: a behavioural controller drives the strobes, results
// are scored against a plain-arithmetic modexp model.
module tb_modexp_datapath;
  import modexp_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int EW = DEF_EXP_WIDTH;

  logic          clk;
  logic          reset;
  logic          initialize;
  logic          en_multiply;
  logic          en_modulo;
  logic          done;
  logic          input_data_ready;
  logic          is_multiplication_done;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          error;

  modexp_if #(.WIDTH(W), .EXP_WIDTH(EW)) up_if ();

  modexp_datapath #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .up                     (up_if),
    .input_data_ready       (input_data_ready),
    .initialize             (initialize),
    .en_multiply            (en_multiply),
    .en_modulo              (en_modulo),
    .done                   (done),
    .is_multiplication_done (is_multiplication_done),
    .result                 (result),
    .result_valid           (result_valid),
    .error                  (error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic          exp_err_q[$];
  logic [EW-1:0] exp_cnt_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            rv_count = 0;
  ctrl_state_e   ctrl_state;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
    end
  endtask

  function automatic logic [W-1:0] model_modexp(input logic [W-1:0] b, input logic [EW-1:0] e,
                                                input logic [W-1:0] m);
    longint unsigned r, bb, mm;
    if (m == '0) return '0;
    mm = longint'(m);
    r  = 1 % mm;
    bb = longint'(b) % mm;
    for (int i = 0; i < int'(e); i++) r = (r * bb) % mm;
    return W'(r);
  endfunction

  task automatic flush_sb();
    exp_q.delete();
    exp_err_q.delete();
    exp_cnt_q.delete();
  endtask

  always @(negedge clk) begin
    if (!reset && result_valid) begin
      rv_count++;
      if (exp_q.size() == 0) begin
        check_eq("rv_without_job", 32'(result_valid), 32'd0);
      end else begin
        check_eq("result", 32'(result), 32'(exp_q.pop_front()));
        check_eq("error", 32'(error), 32'(exp_err_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_set(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    int guard = 0;
    up_if.in_valid    = 1'b1;
    up_if.in_base     = b;
    up_if.in_exponent = e;
    up_if.in_modulus  = m;
    while (!up_if.in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!up_if.in_ready) begin
      check_eq("push_timeout", 32'(up_if.in_ready), 32'd1);
      up_if.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_modexp(b, e, m));
    exp_err_q.push_back(m == '0);
    exp_cnt_q.push_back(e);
    @(negedge clk);
    up_if.in_valid = 1'b0;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: initialize  = 1'b1;
      1: en_multiply = 1'b1;
      2: en_modulo   = 1'b1;
      default: done  = 1'b1;
    endcase
    @(negedge clk);
    initialize  = 1'b0;
    en_multiply = 1'b0;
    en_modulo   = 1'b0;
    done        = 1'b0;
  endtask

  // Behavioural controller; extra_mul issues one more multiply/modulo pair after the count hits zero.
  task automatic ctrl_job(input bit extra_mul);
    int guard = 0;
    int n_mul = 0;
    ctrl_state = WAITING;
    while (!input_data_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!input_data_ready) begin
      check_eq("ctrl_wait_timeout", 32'(input_data_ready), 32'd1);
      return;
    end
    ctrl_state = INITIALIZE;
    pulse(0);
    while (!is_multiplication_done && n_mul < 1000) begin
      ctrl_state = MULTIPLY;
      pulse(1);
      ctrl_state = MODULO;
      pulse(2);
      n_mul++;
    end
    if (extra_mul) begin
      pulse(1);
      pulse(2);
    end
    if (exp_cnt_q.size() != 0) check_eq("mul_count", 32'(n_mul), 32'(exp_cnt_q.pop_front()));
    ctrl_state = DONE;
    pulse(3);
    @(negedge clk);
    check_eq("rv_one_cycle", 32'(result_valid), 32'd0);
  endtask

  task automatic run_one(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    push_set(b, e, m);
    ctrl_job(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rv_before;
    logic [W-1:0] rb, rm;
    logic [EW-1:0] re;
    reset = 1'b1;
    initialize = 1'b0; en_multiply = 1'b0; en_modulo = 1'b0; done = 1'b0;
    up_if.in_valid = 1'b0; up_if.in_base = '0; up_if.in_exponent = '0; up_if.in_modulus = '0;
    ctrl_state = WAITING;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(up_if.in_ready), 32'd1);
    check_eq("rst_input_data_ready", 32'(input_data_ready), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_result_valid", 32'(result_valid), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_mul_done", 32'(is_multiplication_done), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Directed jobs, including exponent 0 and modulus 1 / 0.
    run_one(16'd3, 16'd5, 16'd7);
    run_one(16'd2, 16'd10, 16'd1000);
    run_one(16'h00FF, 16'd3, 16'hFFFF);
    run_one(16'hFFFF, 16'd4, 16'hFFFE);
    run_one(16'd9, 16'd0, 16'd13);
    run_one(16'd6, 16'd4, 16'd1);
    run_one(16'd6, 16'd3, 16'd0);

    // Back-to-back: second set arrives while the first job runs and is held.
    push_set(16'd9, 16'd6, 16'd11);
    fork
      begin
        ctrl_job(1'b0);
        ctrl_job(1'b0);
      end
      begin
        push_set(16'd5, 16'd3, 16'd23);
        check_eq("b2b_held_in_ready", 32'(up_if.in_ready), 32'd0);
        check_eq("b2b_held_idr", 32'(input_data_ready), 32'd1);
      end
    join

    // Idle DONE->INITIALIZE loops with no data: no pulse.
    rv_before = rv_count;
    repeat (3) begin
      pulse(0);
      check_eq("idle_mul_done", 32'(is_multiplication_done), 32'd1);
      pulse(3);
    end
    @(negedge clk);
    check_eq("idle_no_rv", 32'(rv_count), 32'(rv_before));

    // An extra multiply after the count reaches zero must not change the result.
    push_set(16'd7, 16'd3, 16'd1000);
    ctrl_job(1'b1);

    // Reset mid-job with a second set buffered.
    push_set(16'd9, 16'd8, 16'd101);
    pulse(0);
    push_set(16'd5, 16'd3, 16'd23);
    check_eq("midrst_buffered", 32'(input_data_ready), 32'd1);
    pulse(1);
    reset = 1'b1;
    flush_sb();
    rv_before = rv_count;
    @(negedge clk);
    check_eq("midrst_in_ready", 32'(up_if.in_ready), 32'd1);
    check_eq("midrst_idr", 32'(input_data_ready), 32'd0);
    check_eq("midrst_result", 32'(result), 32'd0);
    check_eq("midrst_mul_done", 32'(is_multiplication_done), 32'd1);
    reset = 1'b0;
    pulse(0);
    pulse(3);
    @(negedge clk);
    check_eq("midrst_no_rv", 32'(rv_count), 32'(rv_before));
    run_one(16'd5, 16'd3, 16'd23);

    // Randomized jobs.
    for (int i = 0; i < 24; i++) begin
      rb = W'($urandom_range(0, 65535));
      re = EW'($urandom_range(0, 12));
      case ($urandom_range(0, 9))
        0:       rm = '0;
        1:       rm = W'(1);
        default: rm = W'($urandom_range(2, 65535));
      endcase
      run_one(rb, re, rm);
    end

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
